dmem_mmio: RTL and testbench
============================

# dmem_mmio

Parametrised successor to the single-cycle data memory: word-addressed RAM plus a bank of memory-mapped 16-bit display registers behind one request/ready port with configurable wait states. It sits between the CPU load/store path and the board display. A time-multiplexed scanner presents one display register at a time to the display driver. Unlike the single-cycle memory it supports byte enables, wait-state handshaking, address error reporting and multiple display channels.

## Interface

Parameters:
- DEPTH_WORDS, 256: RAM size in 32-bit words; power of two, at least 2.
- WAIT_STATES, 1: extra cycles inserted before ready; range 0..15.
- DISP_CHANNELS, 4: number of 16-bit display registers; range 1..16.
- DISP_BASE, 32'h0000_1000: byte address of display register 0; word-aligned; must not overlap the RAM range.
- SCAN_DIV, 1000: clk cycles per scanner channel step; at least 1.

Ports (SW = max(1, $clog2(DISP_CHANNELS))):
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  access request; req, we, be, addr and wdata are held stable until ready.
- we  in  1  1 = write, 0 = read.
- be  in  4  byte enables; be[i] gates wdata[8i+7:8i].
- addr  in  32  byte address.
- wdata  in  32  write data.
- rdata  out  32  read data; valid only while ready=1, 0 otherwise.
- ready  out  1  one-cycle completion strobe.
- err  out  1  valid with ready; 1 = access rejected.
- disp_sel  out  SW  index of the channel being displayed.
- disp_data  out  16  contents of display register disp_sel.

## Operation

- Address decode:
  - RAM hit: addr < 4*DEPTH_WORDS.
  - Display hit: DISP_BASE <= addr < DISP_BASE + 4*DISP_CHANNELS.
  - Word index for either hit is addr[..:2].
  - Error: addr[1:0] != 0, or neither hit. The access completes with err=1 and rdata=0, and nothing is written.
- Handshake FSM states: IDLE, WAIT, RESP.
  - IDLE: if req=1, load cnt = WAIT_STATES. Go to WAIT if WAIT_STATES > 0, otherwise go to RESP.
  - WAIT: if req=0, abort to IDLE with no write. Otherwise decrement cnt; on the edge where cnt = 1, go to RESP.
  - RESP: ready=1, and err and rdata are driven. A write commits on the edge that leaves RESP, provided req=1 and err=0. Always return to IDLE afterwards.
  - If req drops during RESP, the access is abandoned: no write.
- RAM writes:
  - Byte-lane merge under be.
  - be = 0 is a legal no-op and still completes with ready.
  - RAM contents are not reset.
- Display register writes:
  - be[1:0] gate bits [15:0]; wdata[31:16] and be[3:2] are ignored.
  - Reads return {16'h0, reg}.
  - All display registers reset to 0.
- RAM reads return the word addressed during RESP.
- Scanner:
  - A free-running counter runs 0..SCAN_DIV-1.
  - On wrap, disp_sel increments modulo DISP_CHANNELS.
  - With DISP_CHANNELS = 1, disp_sel stays 0.
  - disp_data is combinational from the selected register, so a write appears on disp_data the cycle after its commit edge.

## Timing

- Reset asserted (reset=0):
  - State goes to IDLE immediately and asynchronously.
  - ready=0, err=0, rdata=0, disp_sel=0, disp_data=0, scan counter 0, display registers 0.
  - A pending write is discarded.
- Latency: req sampled at edge E0 gives ready high in the cycle after edge E0+WAIT_STATES.
  - That is WAIT_STATES+1 cycles after req is first seen.
- Throughput: one access per WAIT_STATES+2 cycles, because the IDLE bubble after RESP is mandatory.
- The master may drop req or present a new request in the cycle after ready. The new request is accepted at the next IDLE edge.
- Scanner step: disp_sel changes every SCAN_DIV cycles. It is independent of bus activity and does not stall.

## Test plan

- Reset, WAIT_STATES=1: hold reset=0 for 3 cycles, then release, then idle for 10 cycles -> ready=0, rdata=0, disp_data=0 and disp_sel=0 throughout.
- RAM byte write and readback: write 0xDEADBEEF to addr 0x10 with be=4'hF, then write 0x000000AA with be=4'b0001, then read 0x10 -> rdata=0xDEADBEAA with err=0. Each ready arrives exactly 2 cycles after req; repeat with WAIT_STATES=0 -> 1 cycle.
- Error cases:
  - Read addr 0x13 (misaligned) -> err=1, rdata=0.
  - Write to addr 0x400 with DEPTH_WORDS=256 -> err=1; a following read of 0x0 is unchanged.
  - Access DISP_BASE+0x10 with DISP_CHANNELS=4 -> err=1.
- Display write and scan, SCAN_DIV=4:
  - Write 0x1234 to channel 0 and 0xABCD to channel 1 -> disp_sel steps 0,1,2,3,0 every 4 cycles.
  - disp_data shows 0x1234, then 0xABCD, then 0, 0, then 0x1234 again.
  - Reading channel 1 returns 0x0000ABCD.
- Abort: WAIT_STATES=3; drop req after 2 cycles of a write of 0x55 to addr 0x20 -> no ready pulse, and a later read of 0x20 returns the old value.
- Reset mid-access: assert reset while in WAIT for a write -> ready stays 0 and the target word is unmodified. After release, the first request completes with normal latency.

Source files
------------

// File: rtl/dmem_mmio.sv
// Word-addressed RAM plus memory-mapped 16-bit display registers behind one
// req/ready port with configurable wait states and a time-multiplexed scanner.
module dmem_mmio #(
    parameter int unsigned DEPTH_WORDS   = 256,
    parameter int unsigned WAIT_STATES   = 1,
    parameter int unsigned DISP_CHANNELS = 4,
    parameter logic [31:0] DISP_BASE     = 32'h0000_1000,
    parameter int unsigned SCAN_DIV      = 1000,
    localparam int         SW            = (DISP_CHANNELS > 1) ? $clog2(DISP_CHANNELS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          ready,
    output logic          err,
    output logic [SW-1:0] disp_sel,
    output logic [15:0]   disp_data
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam int          SCW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [32:0] RAM_END  = 33'(DEPTH_WORDS) << 2;
    localparam logic [32:0] DISP_END = {1'b0, DISP_BASE} + (33'(DISP_CHANNELS) << 2);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic          ready_q;
    logic          err_q;
    logic [31:0]   rdata_q;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [15:0]   disp_q [DISP_CHANNELS];
    logic [SCW-1:0] scan_q;
    logic [SW-1:0] sel_q;

    logic          ram_hit;
    logic          disp_hit;
    logic          acc_err;
    logic [AW-1:0] ram_idx;
    logic [SW-1:0] disp_idx;
    logic [31:0]   rd_word;
    logic [31:0]   resp_d;
    logic          commit;
    logic          ram_wr;
    logic          disp_wr;

    // Wide compares keep the range checks correct near the top of the address space.
    always_comb begin
        ram_hit  = ({1'b0, addr} < RAM_END);
        disp_hit = (addr >= DISP_BASE) && ({1'b0, addr} < DISP_END);
        acc_err  = (addr[1:0] != 2'b00) || !(ram_hit || disp_hit);
        ram_idx  = addr[AW+1:2];
        disp_idx = SW'((addr - DISP_BASE) >> 2);
        rd_word  = ram_hit ? mem[ram_idx] : {16'h0000, disp_q[disp_idx]};
        resp_d   = acc_err ? 32'h0 : rd_word;
    end

    // Writes land on the edge that leaves RESP, only if the master still holds req.
    assign commit  = (state_q == S_RESP) && req && we && !acc_err;
    assign ram_wr  = commit && ram_hit;
    assign disp_wr = commit && disp_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        cnt_q <= 4'(WAIT_STATES);
                        if (WAIT_STATES == 0) begin
                            state_q <= S_RESP;
                            ready_q <= 1'b1;
                            err_q   <= acc_err;
                            rdata_q <= resp_d;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_q <= S_RESP;
                            ready_q <= 1'b1;
                            err_q   <= acc_err;
                            rdata_q <= resp_d;
                        end
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= 32'h0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // RAM holds no reset so it maps onto plain block memory.
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < int'(DISP_CHANNELS); c++) disp_q[c] <= 16'h0;
        end else if (disp_wr) begin
            if (be[0]) disp_q[disp_idx][7:0]  <= wdata[7:0];
            if (be[1]) disp_q[disp_idx][15:8] <= wdata[15:8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_q <= '0;
            sel_q  <= '0;
        end else if (scan_q == SCW'(SCAN_DIV - 1)) begin
            scan_q <= '0;
            if (DISP_CHANNELS > 1) begin
                sel_q <= (sel_q == SW'(DISP_CHANNELS - 1)) ? '0 : sel_q + SW'(1);
            end
        end else begin
            scan_q <= scan_q + SCW'(1);
        end
    end

    assign rdata     = rdata_q;
    assign ready     = ready_q;
    assign err       = err_q;
    assign disp_sel  = sel_q;
    assign disp_data = disp_q[sel_q];

endmodule

// File: tb/tb_dmem_mmio.sv
// Randomized scoreboard bench for dmem_mmio: a driver pushes model-predicted
// responses, a negedge monitor pops them on ready and tracks the display scan.
module tb_dmem_mmio;

    localparam int          DEPTH = 256;
    localparam int          WS    = 1;
    localparam int          CH    = 4;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          SD    = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic [1:0]  disp_sel;
    logic [15:0] disp_data;

    dmem_mmio #(
        .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS), .DISP_CHANNELS(CH),
        .DISP_BASE(BASE), .SCAN_DIV(SD)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .be(be), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
        .disp_sel(disp_sel), .disp_data(disp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        bit          chk_rd;
        logic [31:0] rdata;
        int          issue;
        bit          dwr;
        int          ch;
        logic [15:0] val;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ram_m [int];
    logic [15:0] disp_m [CH];
    logic [15:0] shadow [CH];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          edges = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or negedge reset) begin
        if (!reset) edges <= 0;
        else        edges <= edges + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Reference model: decode and merge straight from the address-map rules.
    function automatic exp_t model(input bit w, input logic [3:0] b,
                                   input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        longint      ua;
        bit          rh, dh;
        int          idx;
        logic [31:0] word;
        logic [15:0] v;
        e = '{default: 0};
        ua = longint'(a);
        rh = ua < 4 * DEPTH;
        dh = (ua >= longint'(BASE)) && (ua < longint'(BASE) + 4 * CH);
        e.err = (ua % 4 != 0) || !(rh || dh);
        e.chk_rd = !w || e.err;
        if (!e.err && rh) begin
            idx = int'(ua / 4);
            if (!ram_m.exists(idx)) e.chk_rd = 1'b0;
            word = ram_m.exists(idx) ? ram_m[idx] : 32'h0;
            e.rdata = word;
            if (w) begin
                for (int i = 0; i < 4; i++) if (b[i]) word[8*i +: 8] = d[8*i +: 8];
                ram_m[idx] = word;
            end
        end else if (!e.err) begin
            idx = int'((ua - longint'(BASE)) / 4);
            e.rdata = {16'h0, disp_m[idx]};
            if (w) begin
                v = disp_m[idx];
                if (b[0]) v[7:0]  = d[7:0];
                if (b[1]) v[15:8] = d[15:8];
                disp_m[idx] = v;
                e.dwr = 1'b1;
                e.ch  = idx;
                e.val = v;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        int   s;
        if (!reset) begin
            chk("rst_ready", {31'h0, ready}, 32'h0);
            chk("rst_rdata", rdata, 32'h0);
            chk("rst_disp_sel", {30'h0, disp_sel}, 32'h0);
            chk("rst_disp_data", {16'h0, disp_data}, 32'h0);
            for (int c = 0; c < CH; c++) shadow[c] = 16'h0;
            q.delete();
        end else begin
            s = (edges / SD) % CH;
            chk("disp_sel", {30'h0, disp_sel}, 32'(s));
            chk("disp_data", {16'h0, disp_data}, {16'h0, shadow[s]});
            if (ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_ready: got ready=1 expected no response (t=%0t)", $time);
                end else begin
                    e = q.pop_front();
                    chk("err", {31'h0, err}, {31'h0, e.err});
                    chk("latency", 32'(cyc - e.issue), 32'(WS + 1));
                    if (e.chk_rd) chk("rdata", rdata, e.rdata);
                    if (e.dwr) shadow[e.ch] = e.val;
                end
            end else begin
                chk("idle_rdata", rdata, 32'h0);
            end
        end
    end

    task automatic access(input bit w, input logic [3:0] b, input logic [31:0] a,
                          input logic [31:0] d, input int abort_after);
        exp_t e;
        bit   got;
        @(negedge clk);
        if (abort_after < 0) begin
            e = model(w, b, a, d);
            e.issue = cyc;
            q.push_back(e);
        end
        req = 1'b1; we = w; be = b; addr = a; wdata = d;
        if (abort_after >= 0) begin
            repeat (abort_after) @(negedge clk);
            req = 1'b0;
            repeat (WS + 3) @(negedge clk);
        end else begin
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                if (ready) got = 1'b1;
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL timeout: got no ready expected ready for addr %h", a);
            end
            @(negedge clk);
            req = 1'b0;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #1;
        reset = 1'b0;
        req = 1'b0;
        for (int c = 0; c < CH; c++) disp_m[c] = 16'h0;
        repeat (n) @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        for (int c = 0; c < CH; c++) begin disp_m[c] = 16'h0; shadow[c] = 16'h0; end
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b1;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 18; i++)
            access(1'b1, 4'hF, 32'((i < 16 ? i : 238 + i) * 4), $urandom, -1);

        access(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, -1);
        access(1'b1, 4'b0001, 32'h10, 32'h000000AA, -1);
        access(1'b0, 4'hF, 32'h10, 32'h0, -1);
        access(1'b0, 4'hF, 32'h13, 32'h0, -1);
        access(1'b1, 4'hF, 32'h400, 32'h12345678, -1);
        access(1'b0, 4'hF, 32'h0, 32'h0, -1);
        access(1'b0, 4'hF, BASE + 32'h10, 32'h0, -1);
        access(1'b1, 4'h0, 32'h14, 32'hFFFFFFFF, -1);
        access(1'b0, 4'hF, 32'h14, 32'h0, -1);
        access(1'b0, 4'hF, 32'h3FC, 32'h0, -1);

        access(1'b1, 4'hF, BASE, 32'hFFFF1234, -1);
        access(1'b1, 4'b0011, BASE + 32'h4, 32'h0000ABCD, -1);
        repeat (20) @(negedge clk);
        access(1'b0, 4'hF, BASE + 32'h4, 32'h0, -1);

        access(1'b1, 4'hF, 32'h20, 32'h55, 1);
        access(1'b0, 4'hF, 32'h20, 32'h0, -1);

        @(negedge clk);
        req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h24; wdata = 32'hCAFEF00D;
        do_reset(2);
        repeat (2) @(negedge clk);
        access(1'b0, 4'hF, 32'h24, 32'h0, -1);
        access(1'b1, 4'hF, BASE + 32'h8, 32'h00005A5A, -1);

        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 17);
            case ($urandom_range(0, 5))
                0, 1: a = 32'((r < 16 ? r : 238 + r) * 4);
                2:    a = 32'((r < 16 ? r : 238 + r) * 4 + $urandom_range(1, 3));
                3:    a = ($urandom_range(0, 1) == 0) ? 32'h400 + 32'(4 * $urandom_range(0, 255))
                                                      : 32'hFFFF_FFFC;
                4:    a = BASE + 32'(4 * $urandom_range(0, CH - 1));
                default: a = ($urandom_range(0, 1) == 0) ? BASE - 32'h4 : BASE + 32'(4 * CH);
            endcase
            access($urandom_range(0, 1) == 1, 4'($urandom), a, $urandom,
                   ($urandom_range(0, 9) == 0) ? 1 : -1);
        end

        repeat (10) @(negedge clk);
        chk("pending_responses", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
